i2s_tx_serializer: RTL and testbench

//  Stereo I2S transmitter, downstream of the programmable clock divider. Accepts parallel

---
 rtl/i2s_tx_serializer_if.sv | 23 ++
 rtl/i2s_tx_serializer.sv | 126 ++++++++++++
 tb/tb_i2s_tx_serializer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair stream into the I2S transmitter: valid/ready with parallel left/right words.
interface i2s_tx_serializer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready
  );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Stereo Philips-I2S transmitter. BCLK is divided down from clk so everything stays in one
// clock domain; a one-entry holding register decouples the sample source from frame timing.
module i2s_tx_serializer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DIV_W-1:0]    bclk_div,
  i2s_tx_serializer_if.slave  smp,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sd,
  output logic                underrun
);

  localparam int unsigned     FrameW     = 2 * DATA_W;
  localparam int unsigned     CntW       = $clog2(FrameW);
  localparam logic [CntW-1:0] LastBit    = CntW'(FrameW - 1);
  localparam logic [CntW-1:0] RightFirst = CntW'(DATA_W);
  localparam logic [CntW-1:0] LoadBit    = CntW'(1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state;
  logic [DIV_W-1:0]  div_lat;
  logic [DIV_W-1:0]  half_cnt;
  logic [CntW-1:0]   bit_cnt;
  logic [CntW-1:0]   bit_cnt_nxt;
  logic [FrameW-1:0] shift;
  logic [FrameW-1:0] hold;
  logic              hold_full;
  logic              ready_q;
  logic              half_done;
  logic              accept;

  assign smp.s_ready = ready_q;

  // Decode the current half-period end, the wrapped bit index and the handshake.
  always_comb begin
    half_done   = (half_cnt == div_lat);
    bit_cnt_nxt = (bit_cnt == LastBit) ? '0 : bit_cnt + 1'b1;
    accept      = smp.s_valid && ready_q;
  end

  // Run/idle FSM with BCLK divider, frame counter, shifter and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      div_lat   <= '0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b1;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sd    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;

      // Accept never coincides with a load: ready is low whenever the register is full.
      if (accept) begin
        hold      <= {smp.s_left, smp.s_right};
        hold_full <= 1'b1;
        ready_q   <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (enable) begin
            state    <= StRun;
            div_lat  <= bclk_div;
            half_cnt <= '0;
          end
        end
        StRun: begin
          if (!enable) begin
            // Abandon the frame; the holding register keeps any pending pair.
            state     <= StIdle;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sd    <= 1'b0;
          end else if (half_done) begin
            half_cnt <= '0;
            i2s_bclk <= ~i2s_bclk;
            // BCLK falling: every serial output moves on this clk.
            if (i2s_bclk) begin
              bit_cnt   <= bit_cnt_nxt;
              i2s_lrclk <= (bit_cnt_nxt >= RightFirst);
              // Period only changes on a frame boundary.
              if (bit_cnt_nxt == '0) begin
                div_lat <= bclk_div;
              end
              // Load one bit after LRCLK falls (Philips one-bit delay).
              if (bit_cnt_nxt == LoadBit) begin
                if (hold_full) begin
                  shift     <= hold;
                  i2s_sd    <= hold[FrameW-1];
                  hold_full <= 1'b0;
                  ready_q   <= 1'b1;
                end else begin
                  shift    <= '0;
                  i2s_sd   <= 1'b0;
                  underrun <= 1'b1;
                end
              end else begin
                shift  <= shift << 1;
                i2s_sd <= shift[FrameW-2];
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for the I2S transmitter: DATA_W=16, mostly bclk_div=1 (4 clk per bit).
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  bclk_div = 8'd1;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sd;
  logic        underrun;

  int          n_checks = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned n_under = 0;

  i2s_tx_serializer_if #(.DATA_W(16)) smp_if ();

  i2s_tx_serializer #(
    .DATA_W(16),
    .DIV_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bclk_div (bclk_div),
    .smp      (smp_if),
    .i2s_bclk (i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sd   (i2s_sd),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (underrun) n_under <= n_under + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for the next BCLK rising edge (seen at a falling clk edge) and sample SD/LRCLK.
  task automatic next_rise(output logic sd, output logic lr, output int unsigned t);
    logic prev;
    sd = 1'b0;
    lr = 1'b0;
    t  = 0;
    for (int i = 0; i < 64; i++) begin
      prev = i2s_bclk;
      @(negedge clk);
      if (i2s_bclk && !prev) begin
        sd = i2s_sd;
        lr = i2s_lrclk;
        t  = cyc;
        return;
      end
    end
    check_eq("rise_timeout", 0, 1);
  endtask

  // Return at the rising edge carrying bit_cnt=0 (first sample after LRCLK falls).
  task automatic sync_frame();
    logic sd, lr, lr_prev;
    int unsigned t;
    lr_prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      next_rise(sd, lr, t);
      if (!lr && lr_prev) return;
      lr_prev = lr;
    end
    check_eq("sync_timeout", 0, 1);
  endtask

  task automatic grab32(output logic [31:0] d, output logic [31:0] l);
    logic sd, lr;
    int unsigned t;
    d = '0;
    l = '0;
    for (int i = 0; i < 32; i++) begin
      next_rise(sd, lr, t);
      d = {d[30:0], sd};
      l = {l[30:0], lr};
    end
  endtask

  task automatic push(input logic [15:0] left, input logic [15:0] right);
    smp_if.s_left  = left;
    smp_if.s_right = right;
    smp_if.s_valid = 1'b1;
    for (int i = 0; i < 600 && !smp_if.s_ready; i++) @(negedge clk);
    check_eq("push_ready", smp_if.s_ready, 1);
    @(posedge clk);
    #1 smp_if.s_valid = 1'b0;
    @(negedge clk);
  endtask

  // Wait for s_ready to rise and confirm it coincides with a BCLK falling edge (the load).
  task automatic wait_ready(input string tag);
    logic last;
    last = i2s_bclk;
    for (int i = 0; i < 600 && !smp_if.s_ready; i++) begin
      last = i2s_bclk;
      @(negedge clk);
    end
    check_eq(tag, {smp_if.s_ready, last, i2s_bclk}, 3'b110);
  endtask

  initial begin
    logic [31:0] d, l;
    logic        sd, lr;
    int unsigned t, t0, t1, t2, t3, u0, hi_cnt, sd_ones, ur_snap;

    smp_if.s_valid = 1'b0;
    smp_if.s_left  = '0;
    smp_if.s_right = '0;

    // Reset with enable already high.
    enable = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {i2s_bclk, i2s_lrclk, i2s_sd, underrun}, 4'b0000);
    check_eq("rst_ready", smp_if.s_ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && !i2s_bclk; i++) @(negedge clk);
    check_eq("bclk_starts", i2s_bclk, 1);

    // No samples: underrun every 128 clk, silent SD, LRCLK 50% duty.
    for (int i = 0; i < 300 && !underrun; i++) @(negedge clk);
    check_eq("ur_first", underrun, 1);
    u0      = cyc;
    hi_cnt  = 0;
    sd_ones = 0;
    for (int i = 0; i < 300; i++) begin
      hi_cnt  += i2s_lrclk;
      sd_ones += i2s_sd;
      @(negedge clk);
      if (underrun) break;
    end
    check_eq("ur_period", cyc - u0, 128);
    check_eq("lr_duty", hi_cnt, 64);
    check_eq("sd_silent", sd_ones, 0);

    // One pair, serialized MSB first with the one-bit delay.
    push(16'hA55A, 16'h0F0F);
    sync_frame();
    grab32(d, l);
    check_eq("a55a_data", d, 32'hA55A0F0F);
    check_eq("a55a_lr", l, 32'h0001FFFE);

    // Back-to-back pairs with s_valid held high.
    for (int i = 0; i < 300 && !underrun; i++) @(negedge clk);
    @(negedge clk);
    ur_snap = n_under;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          smp_if.s_left  = 16'(2 * k + 1);
          smp_if.s_right = 16'(2 * k + 2);
          smp_if.s_valid = 1'b1;
          if (k > 0) wait_ready("ready_rise");
          @(posedge clk);
          @(negedge clk);
          check_eq("ready_drop", smp_if.s_ready, 0);
        end
        smp_if.s_valid = 1'b0;
        wait_ready("ready_rise_last");
      end
      begin
        sync_frame();
        for (int j = 0; j < 3; j++) begin
          grab32(d, l);
          check_eq("seq_data", d, {16'(2 * j + 1), 16'(2 * j + 2)});
          check_eq("seq_lr", l, 32'h0001FFFE);
        end
      end
    join
    check_eq("seq_no_underrun", n_under - ur_snap, 0);

    // Currently at the bit_cnt=0 sample; change divider at bit_cnt=5.
    for (int i = 1; i <= 5; i++) next_rise(sd, lr, t);
    bclk_div = 8'd3;
    t0 = 0;
    t1 = 0;
    for (int i = 6; i <= 31; i++) begin
      next_rise(sd, lr, t);
      if (i == 30) t0 = t;
      if (i == 31) t1 = t;
    end
    next_rise(sd, lr, t);
    next_rise(sd, lr, t2);
    next_rise(sd, lr, t3);
    check_eq("old_rate", t1 - t0, 4);
    check_eq("new_rate", t3 - t2, 8);
    for (int i = 0; i < 31; i++) next_rise(sd, lr, t);
    check_eq("new_frame_len", t - t2, 256);

    // Disable mid-frame with a pending pair, then re-enable.
    bclk_div = 8'd1;
    sync_frame();
    next_rise(sd, lr, t);
    next_rise(sd, lr, t);
    push(16'h8001, 16'h7FFE);
    for (int i = 3; i <= 9; i++) next_rise(sd, lr, t);
    enable = 1'b0;
    @(negedge clk);
    check_eq("idle_outs", {i2s_bclk, i2s_lrclk, i2s_sd}, 3'b000);
    check_eq("idle_ready", smp_if.s_ready, 0);
    repeat (4) @(negedge clk);
    check_eq("idle_hold", {i2s_bclk, i2s_lrclk, i2s_sd, smp_if.s_ready}, 4'b0000);
    enable = 1'b1;
    next_rise(sd, lr, t);
    grab32(d, l);
    check_eq("reen_data", d, 32'h80017FFE);
    check_eq("reen_lr", l, 32'h0001FFFE);

    // Asynchronous reset in the right-channel half with a pair pending.
    for (int i = 0; i < 40; i++) begin
      next_rise(sd, lr, t);
      if (lr) break;
    end
    push(16'h1234, 16'h5678);
    check_eq("pre_rst", {i2s_bclk, i2s_lrclk, smp_if.s_ready}, 3'b110);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs", {i2s_bclk, i2s_lrclk, i2s_sd, underrun}, 4'b0000);
    check_eq("async_rst_ready", smp_if.s_ready, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
